// File: rtl/lifo_pkg.sv
// Shared types and constants for the LIFO stream reverser.
package lifo_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        FILL,
        DRAIN
    } rev_state_t;

endpackage

// File: rtl/lifo_rev_obuf.sv
// Two-entry registered FIFO carrying {last, data} on the reverser output.
module lifo_rev_obuf #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        count
);

    logic [DATA_W:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic            wr;
    logic            rd;

    // The producer only writes when it has reserved room, so no in_ready is needed.
    assign wr = in_valid;
    assign rd = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= {in_last, in_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, wr} - {1'b0, rd};
        end
    end

    assign out_valid             = (count_q != 2'd0);
    assign {out_last, out_data}  = mem_q[rd_ptr_q];
    assign count                 = count_q;

endmodule

// File: rtl/lifo_reverser.sv
// Stream reverser: pushes a frame (or DEPTH-word segment) into the LIFO, then pops it back out.
module lifo_reverser #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              lf_push,
    output logic              lf_pop,
    output logic [DATA_W-1:0] lf_data_in,
    input  logic [DATA_W-1:0] lf_data_out,
    input  logic              lf_full,
    input  logic              lf_empty,
    output logic              busy,
    output logic              err_split
);

    import lifo_pkg::rev_state_t;
    import lifo_pkg::FILL;
    import lifo_pkg::DRAIN;

    localparam logic [CNT_W-1:0] CntDepth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    rev_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inflight_q;
    logic             pop_last_q, pop_last_d;
    logic [1:0]       occ;
    logic             hs;
    logic [2:0]       lvl;

    assign hs         = m_valid && m_ready;
    assign lf_data_in = s_data;
    assign busy       = (state_q == DRAIN);

    // Buffer level after this cycle's handshake, counting the pop still in flight.
    assign lvl = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, hs};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pop_last_d = pop_last_q;
        s_ready    = 1'b0;
        lf_push    = 1'b0;
        lf_pop     = 1'b0;
        err_split  = 1'b0;
        case (state_q)
            FILL: begin
                s_ready = !rst && (cnt_q < CntDepth);
                if (s_valid && s_ready) begin
                    lf_push   = 1'b1;
                    cnt_d     = cnt_q + CntOne;
                    err_split = (cnt_q == CntLast) && !s_last;
                    if (s_last || (cnt_q == CntLast)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((cnt_q != '0) && (lvl < 3'd2)) begin
                    lf_pop     = 1'b1;
                    cnt_d      = cnt_q - CntOne;
                    pop_last_d = (cnt_q == CntOne);
                end
                if ((cnt_q == '0) && !inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && hs))) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            pop_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= lf_pop;
            pop_last_q <= pop_last_d;
        end
    end

    lifo_rev_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   (lf_data_out),
        .in_last   (pop_last_q),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_last  (m_last),
        .count     (occ)
    );

    a_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(lf_push && lf_pop));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(lf_push && lf_full));
    a_drain_no_ready: assert property (@(posedge clk) disable iff (rst) busy |-> !s_ready);
    a_empty_after_last_pop: assert property (@(posedge clk) disable iff (rst)
        (inflight_q && (cnt_q == '0)) |-> lf_empty);

endmodule

// File: tb/tb_lifo_reverser.sv
// Directed self-checking bench for lifo_reverser with a behavioural LIFO attached.
module tb_lifo_reverser;

    import lifo_pkg::*;

    localparam int unsigned CNT_W = 5;

    logic  clk = 1'b0;
    logic  rst;
    logic  s_valid, s_ready, s_last;
    word_t s_data;
    logic  m_valid, m_ready, m_last;
    word_t m_data;
    logic  lf_push, lf_pop, lf_full, lf_empty;
    word_t lf_data_in, lf_data_out;
    logic  busy, err_split;

    always #5 clk = ~clk;

    lifo_reverser #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .lf_push     (lf_push),
        .lf_pop      (lf_pop),
        .lf_data_in  (lf_data_in),
        .lf_data_out (lf_data_out),
        .lf_full     (lf_full),
        .lf_empty    (lf_empty),
        .busy        (busy),
        .err_split   (err_split)
    );

    // Behavioural LIFO: registered data_out and flags, same reset as the block.
    word_t lmem [DEPTH];
    int    sp;

    always @(posedge clk) begin
        if (rst) begin
            sp          <= 0;
            lf_data_out <= '0;
            lf_full     <= 1'b0;
            lf_empty    <= 1'b1;
        end else if (lf_push && sp < int'(DEPTH)) begin
            lmem[sp] <= lf_data_in;
            sp       <= sp + 1;
            lf_full  <= (sp + 1 == int'(DEPTH));
            lf_empty <= 1'b0;
        end else if (lf_pop && sp > 0) begin
            lf_data_out <= lmem[sp-1];
            sp          <= sp - 1;
            lf_full     <= 1'b0;
            lf_empty    <= (sp == 1);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic  last;
        word_t data;
        int    cyc;
    } obs_t;

    obs_t  out_q[$];
    int    pp_viol = 0, rd_viol = 0, hold_viol = 0, err_cnt = 0;
    word_t err_data = '0;
    logic  stall_prev = 1'b0;
    logic  held_last;
    word_t held_data;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (m_valid && m_ready) out_q.push_back('{m_last, m_data, cyc});
            if (lf_push && lf_pop) pp_viol <= pp_viol + 1;
            if (busy && s_ready) rd_viol <= rd_viol + 1;
            if (stall_prev && (!m_valid || m_data != held_data || m_last != held_last))
                hold_viol <= hold_viol + 1;
            stall_prev <= m_valid && !m_ready;
            held_data  <= m_data;
            held_last  <= m_last;
            if (err_split) begin
                err_cnt  <= err_cnt + 1;
                err_data <= s_data;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input word_t d, input logic last, output int hs_cyc);
        int k = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && k < 200) begin
            step(1);
            k++;
        end
        if (!s_ready) check("send_timeout", 32'(s_ready), 32'd1);
        hs_cyc = cyc;
        step(1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_seq(input word_t base, input int n);
        int h;
        for (int i = 0; i < n; i++) send(base + word_t'(i), (i == n - 1), h);
    endtask

    task automatic wait_out(input int n, input string tag);
        int k = 0;
        while ((out_q.size() < n || busy) && k < 500) begin
            step(1);
            k++;
        end
        if (out_q.size() < n) check(tag, 32'(out_q.size()), 32'(n));
    endtask

    task automatic check_out(input int idx, input word_t d, input logic last, input string tag);
        if (idx < out_q.size()) begin
            check($sformatf("%s_data%0d", tag, idx), 32'(out_q[idx].data), 32'(d));
            check($sformatf("%s_last%0d", tag, idx), 32'(out_q[idx].last), 32'(last));
        end else begin
            check($sformatf("%s_missing%0d", tag, idx), 32'(out_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, k;
        logic [3:0] pat;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        step(3);

        // Reset state while rst is held
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_lf_push", 32'(lf_push), 32'd0);
        check("rst_lf_pop", 32'(lf_pop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_split", 32'(err_split), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // 3-word frame
        send(16'h0001, 1'b0, hs);
        send(16'h0002, 1'b0, hs);
        send(16'h0003, 1'b1, hs);
        wait_out(3, "f3_timeout");
        check_out(0, 16'h0003, 1'b0, "f3");
        check_out(1, 16'h0002, 1'b0, "f3");
        check_out(2, 16'h0001, 1'b1, "f3");
        if (out_q.size() >= 3) begin
            check("f3_first_latency", 32'(out_q[0].cyc - hs), 32'd3);
            check("f3_last_latency", 32'(out_q[2].cyc - hs), 32'd5);
        end
        check("f3_ready_after", 32'(s_ready), 32'd1);

        // 20 words: split into a 16-word segment and a 4-word segment
        out_q.delete();
        send_seq(16'h0100, 20);
        wait_out(20, "f20_timeout");
        for (int i = 0; i < 16; i++) check_out(i, 16'h010F - word_t'(i), (i == 15), "f20a");
        for (int i = 16; i < 20; i++) check_out(i, 16'h0113 - word_t'(i - 16), (i == 19), "f20b");
        check("f20_err_cnt", 32'(err_cnt), 32'd1);
        check("f20_err_data", 32'(err_data), 32'h010F);

        // Back-pressure with m_ready toggling 1,0,0,1
        out_q.delete();
        send(16'hAAAA, 1'b0, hs);
        send(16'hBBBB, 1'b1, hs);
        pat = 4'b1001;
        k = 0;
        while ((out_q.size() < 2 || busy) && k < 40) begin
            m_ready = pat[k % 4];
            step(1);
            k++;
        end
        m_ready = 1'b1;
        check("bp_count", 32'(out_q.size()), 32'd2);
        check_out(0, 16'hBBBB, 1'b0, "bp");
        check_out(1, 16'hAAAA, 1'b1, "bp");
        check("bp_hold_viol", 32'(hold_viol), 32'd0);

        // Single-word frame
        out_q.delete();
        send(16'hBEEF, 1'b1, hs);
        k = 0;
        while (!m_valid && k < 20) begin
            step(1);
            k++;
        end
        check("one_valid_seen", 32'(m_valid), 32'd1);
        step(1);
        check("one_ready_back", 32'(s_ready), 32'd1);
        check("one_busy_low", 32'(busy), 32'd0);
        check("one_count", 32'(out_q.size()), 32'd1);
        check_out(0, 16'hBEEF, 1'b1, "one");

        // Reset during drain of a 5-word frame
        out_q.delete();
        m_ready = 1'b0;
        send_seq(16'h0051, 5);
        step(4);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_m_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        step(1);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        m_ready = 1'b1;
        #1;
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);
        send(16'h0011, 1'b0, hs);
        send(16'h0022, 1'b1, hs);
        wait_out(2, "mid_timeout");
        step(6);
        check("mid_count", 32'(out_q.size()), 32'd2);
        check_out(0, 16'h0022, 1'b0, "mid");
        check_out(1, 16'h0011, 1'b1, "mid");

        // Whole-run protocol observations
        check("push_pop_overlap", 32'(pp_viol), 32'd0);
        check("ready_in_drain", 32'(rd_viol), 32'd0);
        check("hold_viol_total", 32'(hold_viol), 32'd0);
        check("err_split_total", 32'(err_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
